// File: rtl/sobel_pkg.sv
// Shared constants and width helpers for the streaming Sobel engine.
package sobel_pkg;

  localparam int MODE_BIN = 0;  // binary edge map against cfg_thresh
  localparam int MODE_MAG = 1;  // saturated gradient magnitude

  // Gradient width: |Gx|+|Gy| peaks at 6*(2^DATA_W-1), so 3 extra bits suffice.
  function automatic int grad_w(input int data_w);
    return data_w + 3;
  endfunction

  // Width needed to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One image line of storage, addressed by column. Each write slot is read
// in the same cycle (old contents), so cascading two instances gives the
// pixels from one and two lines above the current column.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int DEPTH = 100,
  parameter int WIDTH = 8,
  parameter int AW    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Combinational read returns the value stored before this cycle's write.
  assign rdata = mem[addr];

  // Storage is never cleared; no window reads it before two full lines land.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel engine: raster pixels in, one |Gx|+|Gy| result per
// interior pixel out, two cycles after the pixel that completes its window.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 100,
  parameter int IMG_H  = 100,
  parameter int DATA_W = 8,
  parameter int MODE   = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              pi_flag,
  input  logic [DATA_W-1:0] pi_data,
  input  logic [DATA_W+2:0] cfg_thresh,
  output logic              po_flag,
  output logic [DATA_W-1:0] po_data,
  output logic              frame_done
);

  localparam int GW = grad_w(DATA_W);
  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam logic [GW-1:0] SAT = GW'((2 ** DATA_W) - 1);

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          col_last, row_last;
  logic          win_vld, win_eof;

  logic [DATA_W-1:0] lb0_q, lb1_q;

  // win[row][col]: row 0 = top (oldest line), col 2 = newest column
  logic [2:0][2:0][DATA_W-1:0] win, win_nxt;

  logic signed [GW-1:0] gx, gy, gx_c, gy_c;
  logic        [GW-1:0] ax, ay, mag;
  logic [DATA_W-1:0]    res;

  // bit 0: stage-1 result valid, bit 1: output valid
  logic [1:0] vld_pipe;
  logic [1:0] eof_pipe;

  assign col_last = (col_cnt == CW'(IMG_W - 1));
  assign row_last = (row_cnt == RW'(IMG_H - 1));
  assign win_vld  = pi_flag && (row_cnt >= RW'(2)) && (col_cnt >= CW'(2));
  assign win_eof  = win_vld && col_last && row_last;

  // Raster position of the incoming pixel; wraps straight into the next frame.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (pi_flag) begin
      if (col_last) begin
        col_cnt <= '0;
        row_cnt <= row_last ? '0 : row_cnt + RW'(1);
      end else begin
        col_cnt <= col_cnt + CW'(1);
      end
    end
  end

  sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(DATA_W), .AW(CW)) u_lb0 (
    .clk   (sys_clk),
    .we    (pi_flag),
    .addr  (col_cnt),
    .wdata (pi_data),
    .rdata (lb0_q)
  );

  sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(DATA_W), .AW(CW)) u_lb1 (
    .clk   (sys_clk),
    .we    (pi_flag),
    .addr  (col_cnt),
    .wdata (lb0_q),
    .rdata (lb1_q)
  );

  // Window as it stands once the incoming column has been shifted in.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_nxt[r][0] = win[r][1];
      win_nxt[r][1] = win[r][2];
    end
    win_nxt[0][2] = lb1_q;
    win_nxt[1][2] = lb0_q;
    win_nxt[2][2] = pi_data;
  end

  // Window registers; contents need no reset since validity comes from counters.
  always_ff @(posedge sys_clk) begin
    if (pi_flag) win <= win_nxt;
  end

  function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  // Gradients are taken from the shifted window so stage 1 lands on the
  // edge that consumes the completing pixel.
  always_comb begin
    gx_c = (ext(win_nxt[0][2]) + (ext(win_nxt[1][2]) <<< 1) + ext(win_nxt[2][2]))
         - (ext(win_nxt[0][0]) + (ext(win_nxt[1][0]) <<< 1) + ext(win_nxt[2][0]));
    gy_c = (ext(win_nxt[2][0]) + (ext(win_nxt[2][1]) <<< 1) + ext(win_nxt[2][2]))
         - (ext(win_nxt[0][0]) + (ext(win_nxt[0][1]) <<< 1) + ext(win_nxt[0][2]));
  end

  // Stage 1: register signed Gx/Gy.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      gx <= '0;
      gy <= '0;
    end else if (win_vld) begin
      gx <= gx_c;
      gy <= gy_c;
    end
  end

  // Magnitude and output formatting feeding the stage-2 register.
  always_comb begin
    ax  = gx[GW-1] ? GW'(-gx) : GW'(gx);
    ay  = gy[GW-1] ? GW'(-gy) : GW'(gy);
    mag = ax + ay;
    if (MODE == MODE_BIN) res = (mag >= cfg_thresh) ? '1 : '0;
    else                  res = (mag > SAT) ? '1 : mag[DATA_W-1:0];
  end

  // Valid and end-of-frame tags travel alongside the data; reset drops them.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vld_pipe <= '0;
      eof_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], win_vld};
      eof_pipe <= {eof_pipe[0], win_eof};
    end
  end

  // Stage 2: registered result, held between pulses.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)          po_data <= '0;
    else if (vld_pipe[0]) po_data <= res;
  end

  assign po_flag    = vld_pipe[1];
  assign frame_done = eof_pipe[1];

endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream on a 4x4 image; one magnitude-mode and one
// binary-mode instance share the same input stream.
module tb_sobel_stream;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        pi_flag = 1'b0;
  logic [7:0]  pi_data = '0;
  logic [10:0] cfg_thresh = '0;

  logic       po_flag_m, fd_m;
  logic [7:0] po_data_m;
  logic       po_flag_b, fd_b;
  logic [7:0] po_data_b;

  int tot = 0;
  int bad = 0;
  int cyc = 0;

  int mag_d[$];
  int mag_c[$];
  int mag_f[$];
  int bin_d[$];
  int bin_f[$];
  int exp_cyc[$];

  always #5 sys_clk = ~sys_clk;

  sobel_stream #(.IMG_W(4), .IMG_H(4), .DATA_W(8), .MODE(1)) dut_mag (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .pi_flag    (pi_flag),
    .pi_data    (pi_data),
    .cfg_thresh (cfg_thresh),
    .po_flag    (po_flag_m),
    .po_data    (po_data_m),
    .frame_done (fd_m)
  );

  sobel_stream #(.IMG_W(4), .IMG_H(4), .DATA_W(8), .MODE(0)) dut_bin (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .pi_flag    (pi_flag),
    .pi_data    (pi_data),
    .cfg_thresh (cfg_thresh),
    .po_flag    (po_flag_b),
    .po_data    (po_data_b),
    .frame_done (fd_b)
  );

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Record every output pulse and the cycle it appeared in.
  always @(negedge sys_clk) begin
    if (po_flag_m) begin
      mag_d.push_back(int'(po_data_m));
      mag_c.push_back(cyc);
      mag_f.push_back(int'(fd_m));
    end else if (fd_m) begin
      mag_f.push_back(2);  // frame_done without po_flag, flagged as illegal
      mag_d.push_back(-1);
      mag_c.push_back(cyc);
    end
    if (po_flag_b) begin
      bin_d.push_back(int'(po_data_b));
      bin_f.push_back(int'(fd_b));
    end
  end

  function automatic logic [7:0] pix(input int scn, input int r, input int c);
    logic [7:0] v;
    case (scn)
      1:       v = 8'd50;
      2:       v = (c >= 2) ? 8'd255 : 8'd0;
      default: v = (r >= 2) ? 8'd12 : 8'd10;
    endcase
    return v;
  endfunction

  task automatic clear_q();
    mag_d.delete(); mag_c.delete(); mag_f.delete();
    bin_d.delete(); bin_f.delete(); exp_cyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk); #1;
      pi_flag = 1'b0;
    end
  endtask

  // Sends a 4x4 frame; gaps are never inserted before pixel (0,0).
  task automatic send_frame(input int scn, input int gap_max, input int npix);
    int k = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (k < npix) begin
          if (gap_max > 0 && k > 0) begin
            int g = $urandom_range(gap_max, 0);
            repeat (g) begin
              @(posedge sys_clk); #1;
              pi_flag = 1'b0;
            end
          end
          @(posedge sys_clk); #1;
          pi_flag = 1'b1;
          pi_data = pix(scn, r, c);
          if (r >= 2 && c >= 2) exp_cyc.push_back(cyc);
        end
        k++;
      end
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    tot++;
    if ({po_flag_m, fd_m, po_data_m} !== 10'd0) begin
      bad++;
      $display("FAIL reset_mag: got flag=%b fd=%b data=%0d want 0/0/0", po_flag_m, fd_m, po_data_m);
    end
    tot++;
    if ({po_flag_b, fd_b, po_data_b} !== 10'd0) begin
      bad++;
      $display("FAIL reset_bin: got flag=%b fd=%b data=%0d want 0/0/0", po_flag_b, fd_b, po_data_b);
    end
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
  endtask

  task automatic test_flat();
    clear_q();
    send_frame(1, 0, 16);
    idle(6);
    tot++;
    if (mag_d.size() != 4) begin
      bad++;
      $display("FAIL flat_count: got %0d want 4", mag_d.size());
    end
    for (int i = 0; i < mag_d.size() && i < 4; i++) begin
      tot++;
      if (mag_d[i] != 0) begin
        bad++;
        $display("FAIL flat_data[%0d]: got %0d want 0", i, mag_d[i]);
      end
      tot++;
      if (mag_f[i] != ((i == 3) ? 1 : 0)) begin
        bad++;
        $display("FAIL flat_fd[%0d]: got %0d want %0d", i, mag_f[i], (i == 3) ? 1 : 0);
      end
      tot++;
      if (mag_c[i] - exp_cyc[i] != 2) begin
        bad++;
        $display("FAIL flat_latency[%0d]: got %0d want 2", i, mag_c[i] - exp_cyc[i]);
      end
    end
  endtask

  task automatic test_step();
    clear_q();
    send_frame(2, 0, 16);
    idle(6);
    tot++;
    if (mag_d.size() != 4) begin
      bad++;
      $display("FAIL step_count: got %0d want 4", mag_d.size());
    end
    for (int i = 0; i < mag_d.size() && i < 4; i++) begin
      tot++;
      if (mag_d[i] != 255) begin
        bad++;
        $display("FAIL step_sat[%0d]: got %0d want 255", i, mag_d[i]);
      end
    end
  endtask

  task automatic test_ramp();
    clear_q();
    send_frame(3, 0, 16);
    idle(6);
    tot++;
    if (mag_d.size() != 4) begin
      bad++;
      $display("FAIL ramp_count: got %0d want 4", mag_d.size());
    end
    for (int i = 0; i < mag_d.size() && i < 4; i++) begin
      tot++;
      if (mag_d[i] != 8) begin
        bad++;
        $display("FAIL ramp_mag[%0d]: got %0d want 8", i, mag_d[i]);
      end
    end
  endtask

  task automatic test_thresh();
    clear_q();
    cfg_thresh = 11'd9;
    send_frame(3, 0, 16);
    idle(6);
    cfg_thresh = 11'd8;
    send_frame(3, 0, 16);
    idle(6);
    tot++;
    if (bin_d.size() != 8) begin
      bad++;
      $display("FAIL thresh_count: got %0d want 8", bin_d.size());
    end
    for (int i = 0; i < bin_d.size() && i < 8; i++) begin
      tot++;
      if (bin_d[i] != ((i < 4) ? 0 : 255)) begin
        bad++;
        $display("FAIL thresh_bin[%0d]: got %0d want %0d", i, bin_d[i], (i < 4) ? 0 : 255);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nfd = 0;
    clear_q();
    send_frame(2, 3, 16);
    send_frame(2, 3, 16);
    idle(8);
    tot++;
    if (mag_d.size() != 8) begin
      bad++;
      $display("FAIL b2b_count: got %0d want 8", mag_d.size());
    end
    for (int i = 0; i < mag_d.size() && i < 8; i++) begin
      if (mag_f[i] == 1) nfd++;
      tot++;
      if (mag_d[i] != 255) begin
        bad++;
        $display("FAIL b2b_data[%0d]: got %0d want 255", i, mag_d[i]);
      end
      tot++;
      if (mag_c[i] - exp_cyc[i] != 2) begin
        bad++;
        $display("FAIL b2b_latency[%0d]: got %0d want 2", i, mag_c[i] - exp_cyc[i]);
      end
      tot++;
      if (mag_f[i] != ((i % 4 == 3) ? 1 : 0)) begin
        bad++;
        $display("FAIL b2b_fd[%0d]: got %0d want %0d", i, mag_f[i], (i % 4 == 3) ? 1 : 0);
      end
    end
    tot++;
    if (nfd != 2) begin
      bad++;
      $display("FAIL b2b_fd_total: got %0d want 2", nfd);
    end
  endtask

  task automatic test_abort();
    clear_q();
    send_frame(3, 0, 6);
    @(posedge sys_clk); #1;
    pi_flag = 1'b0;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    tot++;
    if ({po_flag_m, fd_m, po_data_m} !== 10'd0) begin
      bad++;
      $display("FAIL abort_rst_out: got flag=%b fd=%b data=%0d want 0/0/0", po_flag_m, fd_m, po_data_m);
    end
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    clear_q();
    send_frame(3, 0, 16);
    idle(6);
    tot++;
    if (mag_d.size() != 4) begin
      bad++;
      $display("FAIL abort_count: got %0d want 4", mag_d.size());
    end
    for (int i = 0; i < mag_d.size() && i < 4; i++) begin
      tot++;
      if (mag_d[i] != 8) begin
        bad++;
        $display("FAIL abort_data[%0d]: got %0d want 8", i, mag_d[i]);
      end
      tot++;
      if (mag_f[i] != ((i == 3) ? 1 : 0)) begin
        bad++;
        $display("FAIL abort_fd[%0d]: got %0d want %0d", i, mag_f[i], (i == 3) ? 1 : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_step();
    test_ramp();
    test_thresh();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
